pulse_seq_ctrl: RTL

Programmable pulse-train controller for the VLC transmit path. It accepts a start strobe with a configuration of delay, width, gap and count. It then drives a train of `i_count` pulses on `o_pulse`, with `o_busy`/`o_done` handshakes so upstream logic (UART framing, test sequencers) can schedule the LED driver. It replaces fixed, parameter-only one-shot pulse generation with run-time sequencing.

---
 rtl/pulse_seq_ctrl_pkg.sv | 21 ++
 rtl/pulse_seq_ctrl_if.sv | 27 ++
 rtl/pulse_seq_ctrl_cnt.sv | 26 ++
 rtl/pulse_seq_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pulse_seq_ctrl_pkg.sv
// Shared types for the pulse-train controller: FSM state encoding, default field widths, clamp helper.
// Latency: n/a (declarations only).  Backpressure: n/a.
package pulse_pkg;

    localparam int CW_DEF = 32;
    localparam int NW_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Zero-length phases would merge adjacent pulses, so treat 0 as 1.
    function automatic logic [31:0] clamp1(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/pulse_seq_ctrl_if.sv
// Start/config request and pulse/status response bundle between a sequencer and the pulse controller.
// Latency: n/a (wires only).  Backpressure: none; start is only honoured while the controller is idle.
interface pulse_seq_ctrl_if #(
    parameter int CW = 32,
    parameter int NW = 16
);
    logic          start;
    logic          abort;
    logic [CW-1:0] delay;
    logic [CW-1:0] width;
    logic [CW-1:0] gap;
    logic [NW-1:0] count;
    logic          pulse;
    logic          busy;
    logic          done;
    logic [NW-1:0] pulse_idx;

    modport master (
        output start, abort, delay, width, gap, count,
        input  pulse, busy, done, pulse_idx
    );

    modport slave (
        input  start, abort, delay, width, gap, count,
        output pulse, busy, done, pulse_idx
    );
endinterface

// File: rtl/pulse_seq_ctrl_cnt.sv
// Loadable down-counter timing the delay/high/low phases; stops at zero and flags it combinationally.
// Latency: load visible one cycle after the loading edge.  Backpressure: none.
module pulse_cnt #(
    parameter int CW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          zero
);
    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/pulse_seq_ctrl.sv
// Run-time programmable pulse-train sequencer (delay, width, gap, count); PULSE_SEQ_INFINITE_EN makes count=0 run until abort.
// Latency: busy at the accepting edge, first pulse delay+1 cycles later; all outputs registered.
// Backpressure: none; start is dropped unless idle, abort ends a train at the next edge.
module pulse_seq_ctrl
    import pulse_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int NW = NW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    pulse_seq_ctrl_if.slave bus
);
    state_t        state;
    logic [CW-1:0] width_q;
    logic [CW-1:0] gap_q;
    logic [NW-1:0] count_q;
    logic [NW-1:0] idx_q;
    logic          pulse_q;
    logic          busy_q;
    logic          done_q;
    logic [NW-1:0] pulse_idx_q;

    logic          accept;
    logic          last;
    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_en;
    logic          cnt_zero;

    pulse_cnt #(.CW(CW)) u_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        accept = (state == ST_IDLE) && bus.start && !bus.abort;
`ifdef PULSE_SEQ_INFINITE_EN
        last   = (count_q != '0) && (idx_q == count_q - NW'(1));
`else
        last   = (idx_q == count_q - NW'(1));
`endif
        cnt_en   = (state == ST_DELAY) || (state == ST_HIGH) || (state == ST_LOW);
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    cnt_val  = (bus.delay != '0) ? bus.delay - CW'(1)
                                                 : CW'(clamp1(32'(bus.width))) - CW'(1);
                end
            end
            ST_DELAY, ST_LOW: begin
                cnt_load = cnt_zero;
                cnt_val  = width_q - CW'(1);
            end
            ST_HIGH: begin
                cnt_load = cnt_zero && !last;
                cnt_val  = gap_q - CW'(1);
            end
            default: ;
        endcase
    end

    // Outputs trail the state by one edge, so o_pulse rises one cycle after HIGH is entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            width_q     <= '0;
            gap_q       <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pulse_idx_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort && (state != ST_IDLE)) begin
                state   <= ST_IDLE;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            width_q     <= CW'(clamp1(32'(bus.width)));
                            gap_q       <= CW'(clamp1(32'(bus.gap)));
`ifdef PULSE_SEQ_INFINITE_EN
                            count_q     <= bus.count;
`else
                            count_q     <= NW'(clamp1(32'(bus.count)));
`endif
                            idx_q       <= '0;
                            pulse_idx_q <= '0;
                            busy_q      <= 1'b1;
                            state       <= (bus.delay != '0) ? ST_DELAY : ST_HIGH;
                        end
                    end
                    ST_DELAY: begin
                        if (cnt_zero) state <= ST_HIGH;
                    end
                    ST_HIGH: begin
                        pulse_q     <= 1'b1;
                        pulse_idx_q <= idx_q;
                        if (cnt_zero) state <= last ? ST_DONE : ST_LOW;
                    end
                    ST_LOW: begin
                        pulse_q <= 1'b0;
                        if (cnt_zero) begin
                            idx_q <= idx_q + NW'(1);
                            state <= ST_HIGH;
                        end
                    end
                    ST_DONE: begin
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.pulse     = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_idx = pulse_idx_q;
endmodule
